// File: rtl/aibnd_dcc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aibnd_dcc_pkg
// Description : Shared types and constants for the AIB DCC calibration path.
// Revision    : 1.0  initial release
// ============================================================================
package aibnd_dcc_pkg;

    localparam int         DCC_CODE_W   = 5;
    localparam logic [4:0] DCC_CODE_MAX = 5'd31;
    localparam int         CLR_CYC      = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        SETTLE = 3'd2,
        VOTE   = 3'd3,
        DECIDE = 3'd4,
        STEP   = 3'd5,
        LOCK   = 3'd6,
        FAIL   = 3'd7
    } dcc_state_e;

    // Number of ones in a window of n samples that counts as a majority.
    function automatic logic [3:0] vote_threshold(input int n);
        return 4'((n + 1) / 2);
    endfunction

endpackage : aibnd_dcc_pkg
`default_nettype wire

// File: rtl/aibnd_dcc_vote.sv
`default_nettype none
// ============================================================================
// Module      : aibnd_dcc_vote
// Description : Two-flop synchronizer for the duty-cycle phase detector plus a
//               windowed ones-counter with majority output. i_start opens a
//               window of VOTE_N samples; o_last flags the final sample cycle
//               and o_valid holds until the next window is opened.
// Revision    : 1.0  initial release
// ============================================================================
module aibnd_dcc_vote
    import aibnd_dcc_pkg::*;
#(
    parameter int VOTE_N = 7
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_pd_async,
    input  logic i_start,
    output logic o_last,
    output logic o_valid,
    output logic o_majority
);

    logic       r_pd_s1;
    logic       r_pd_s2;
    logic       r_active;
    logic [3:0] r_cnt;
    logic [3:0] r_ones;
    logic       r_valid;
    logic       w_last;

    assign w_last     = r_active && (r_cnt == 4'(VOTE_N - 1));
    assign o_last     = w_last;
    assign o_valid    = r_valid;
    assign o_majority = (r_ones >= vote_threshold(VOTE_N));

    // Bring the asynchronous detector output into the clk domain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pd_s1 <= 1'b0;
            r_pd_s2 <= 1'b0;
        end else begin
            r_pd_s1 <= i_pd_async;
            r_pd_s2 <= r_pd_s1;
        end
    end

    // Accumulate one synchronized sample per cycle across the vote window.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_active <= 1'b0;
            r_cnt    <= 4'd0;
            r_ones   <= 4'd0;
            r_valid  <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= 4'd0;
            r_ones   <= 4'd0;
            r_valid  <= 1'b0;
        end else if (r_active) begin
            r_ones <= r_ones + {3'b000, r_pd_s2};
            r_cnt  <= r_cnt + 4'd1;
            if (w_last) begin
                r_active <= 1'b0;
                r_valid  <= 1'b1;
            end
        end
    end

endmodule : aibnd_dcc_vote
`default_nettype wire

// File: rtl/aibnd_dcc_cal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aibnd_dcc_cal_ctrl
// Description : DCC calibration sequencer. Sweeps the up-only DCC counter one
//               code at a time, settles, majority-votes the phase detector and
//               locks on the first satisfied code or fails on saturation.
// Revision    : 1.0  initial release
// ============================================================================
module aibnd_dcc_cal_ctrl
    import aibnd_dcc_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int VOTE_N     = 7
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cal_start,
    input  logic                  pd_out,
    input  logic                  cnt_full,
    input  logic [DCC_CODE_W-1:0] cnt_q,
    output logic                  cnt_dir,
    output logic                  cnt_hold,
    output logic                  cnt_nrst,
    output logic                  cal_busy,
    output logic                  cal_done,
    output logic                  cal_fail,
    output logic [DCC_CODE_W-1:0] cal_code
);

    dcc_state_e            r_state;
    dcc_state_e            w_nxt;
    logic [7:0]            r_cyc;
    logic                  r_start_q;
    logic                  w_start_rise;
    logic                  w_vote_start;
    logic                  w_vote_last;
    logic                  w_vote_valid;
    logic                  w_vote_major;
    logic                  r_cnt_dir;
    logic                  r_cnt_hold;
    logic                  r_cnt_nrst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_fail;
    logic [DCC_CODE_W-1:0] r_code;

    // Reset value of 1 keeps a start level held through reset from retriggering.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_start_q <= 1'b1;
        else       r_start_q <= cal_start;
    end

    assign w_start_rise = cal_start && !r_start_q;

    aibnd_dcc_vote #(
        .VOTE_N (VOTE_N)
    ) u_vote (
        .clk        (clk),
        .nrst       (nrst),
        .i_pd_async (pd_out),
        .i_start    (w_vote_start),
        .o_last     (w_vote_last),
        .o_valid    (w_vote_valid),
        .o_majority (w_vote_major)
    );

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    // Per-state cycle counter, cleared on every state entry or restart.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                                 r_cyc <= 8'd0;
        else if ((w_nxt != r_state) || w_start_rise) r_cyc <= 8'd0;
        else                                       r_cyc <= r_cyc + 8'd1;
    end

    // Next-state logic; a start rise overrides whatever the state decided.
    always_comb begin
        w_nxt        = r_state;
        w_vote_start = 1'b0;
        case (r_state)
            IDLE:   w_nxt = IDLE;
            CLR:    if (r_cyc == 8'(CLR_CYC - 1)) w_nxt = SETTLE;
            SETTLE: begin
                if (r_cyc == 8'(SETTLE_CYC - 1)) begin
                    w_nxt        = VOTE;
                    w_vote_start = 1'b1;
                end
            end
            VOTE:   if (w_vote_last) w_nxt = DECIDE;
            DECIDE: begin
                if (w_vote_valid && !w_vote_major) w_nxt = LOCK;
                else if (cnt_full)                 w_nxt = FAIL;
                else                               w_nxt = STEP;
            end
            STEP:   w_nxt = SETTLE;
            LOCK:   w_nxt = LOCK;
            FAIL:   w_nxt = FAIL;
            default: w_nxt = IDLE;
        endcase
        if (w_start_rise) begin
            w_nxt        = CLR;
            w_vote_start = 1'b0;
        end
    end

    // Status and counter-reset outputs follow the state being entered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt_nrst <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_code     <= '0;
        end else begin
            r_cnt_nrst <= !((w_nxt == IDLE) || (w_nxt == CLR));
            r_busy     <= (w_nxt == CLR) || (w_nxt == SETTLE) || (w_nxt == VOTE) ||
                          (w_nxt == DECIDE) || (w_nxt == STEP);
            r_done     <= (w_nxt == LOCK);
            r_fail     <= (w_nxt == FAIL);
            if (w_nxt == CLR)
                r_code <= '0;
            else if ((r_state == DECIDE) && ((w_nxt == LOCK) || (w_nxt == FAIL)))
                r_code <= cnt_q;
        end
    end

    // Increment strobe launched on negedge so clk & dir is glitch-free.
    always_ff @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt_dir  <= 1'b0;
            r_cnt_hold <= 1'b1;
        end else begin
            r_cnt_dir  <= (r_state == STEP);
            r_cnt_hold <= (r_state != STEP);
        end
    end

    assign cnt_dir  = r_cnt_dir;
    assign cnt_hold = r_cnt_hold;
    assign cnt_nrst = r_cnt_nrst;
    assign cal_busy = r_busy;
    assign cal_done = r_done;
    assign cal_fail = r_fail;
    assign cal_code = r_code;

endmodule : aibnd_dcc_cal_ctrl
`default_nettype wire

// File: tb/tb_aibnd_dcc_cal_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_aibnd_dcc_cal_ctrl
// Description : Directed self-checking bench for aibnd_dcc_cal_ctrl with a
//               behavioral up-counter and a code-driven detector model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aibnd_dcc_cal_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       cal_start = 1'b0;
    logic       pd_out = 1'b0;
    logic       cnt_full;
    logic [4:0] cnt_q;
    logic       cnt_dir, cnt_hold, cnt_nrst, cal_busy, cal_done, cal_fail;
    logic [4:0] cal_code;

    int total = 0;
    int bad   = 0;

    // Behavioral counter and detector model state.
    logic [4:0] m_code = 5'd0;
    int         pulses = 0;
    int         run = 0;
    int         max_run = 0;
    int         since = 0;
    int         thresh = 0;
    logic       noisy = 1'b0;
    logic [6:0] pat = 7'd0;

    int p0;
    int n;

    aibnd_dcc_cal_ctrl #(
        .SETTLE_CYC (16),
        .VOTE_N     (7)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cal_start (cal_start),
        .pd_out    (pd_out),
        .cnt_full  (cnt_full),
        .cnt_q     (cnt_q),
        .cnt_dir   (cnt_dir),
        .cnt_hold  (cnt_hold),
        .cnt_nrst  (cnt_nrst),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .cal_fail  (cal_fail),
        .cal_code  (cal_code)
    );

    always #5 clk = ~clk;

    assign cnt_q    = m_code;
    assign cnt_full = (m_code == 5'd31);

    // Up counter clocked by clk & dir, cleared by cnt_nrst.
    always @(posedge clk or negedge cnt_nrst) begin
        if (!cnt_nrst)                m_code <= 5'd0;
        else if (cnt_dir && !cnt_hold) m_code <= m_code + 5'd1;
    end

    // Pulse count, pulse width and cycles since the last increment.
    always @(posedge clk) begin
        if (cnt_dir) begin
            if (run == 0) pulses <= pulses + 1;
            run <= run + 1;
            if (run + 1 > max_run) max_run <= run + 1;
        end else begin
            run <= 0;
        end
        since <= (cnt_dir && !cnt_hold) ? 0 : since + 1;
    end

    // Detector: wants more while code < thresh; optional noisy window at code 5.
    always @(negedge clk) begin
        if (noisy && (m_code == 5'd5) && (since >= 14) && (since <= 20))
            pd_out <= pat[since - 14];
        else
            pd_out <= (int'(m_code) < thresh);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic restart();
        @(negedge clk) cal_start = 1'b0;
        @(negedge clk) cal_start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (!(cal_done || cal_fail) && (k < budget)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("end_within_budget", 32'(k < budget), 1);
    endtask

    initial begin
        // Reset values
        #2 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dir",  cnt_dir, 0);
        check("rst_hold", cnt_hold, 1);
        check("rst_cnrst", cnt_nrst, 0);
        check("rst_busy", cal_busy, 0);
        check("rst_done", cal_done, 0);
        check("rst_fail", cal_fail, 0);
        check("rst_code", cal_code, 0);

        // Detector satisfied at code 0: lock after 27 cycles, no increments
        @(negedge clk) nrst = 1'b1;
        thresh = 0;
        @(negedge clk) cal_start = 1'b1;
        repeat (26) @(posedge clk);
        #1;
        check("lat_done_early", cal_done, 0);
        check("lat_busy_early", cal_busy, 1);
        @(posedge clk);
        #1;
        check("lat_done", cal_done, 1);
        check("lock0_code", cal_code, 0);
        check("lock0_busy", cal_busy, 0);
        check("lock0_pulses", pulses, 0);
        check("lock0_cnrst", cnt_nrst, 1);

        // Threshold 13: exactly 13 one-cycle increments
        thresh = 13;
        p0 = pulses;
        restart();
        check("restart_busy", cal_busy, 1);
        check("restart_done_clr", cal_done, 0);
        wait_end(1000);
        check("t13_done", cal_done, 1);
        check("t13_fail", cal_fail, 0);
        check("t13_code", cal_code, 13);
        check("t13_pulses", pulses - p0, 13);
        check("t13_width", max_run, 1);

        // Detector stuck at 1: saturate and fail with no 32nd pulse
        thresh = 32;
        p0 = pulses;
        restart();
        wait_end(1500);
        check("sat_fail", cal_fail, 1);
        check("sat_done", cal_done, 0);
        check("sat_code", cal_code, 31);
        check("sat_pulses", pulses - p0, 31);
        repeat (60) @(posedge clk);
        #1;
        check("sat_no_32nd", pulses - p0, 31);
        check("sat_hold", cnt_hold, 1);

        // Noisy detector at code 5: 3 ones of 7 locks at 5
        noisy = 1'b1;
        thresh = 6;
        pat = 7'b0100101;
        restart();
        wait_end(1000);
        check("noisy3_done", cal_done, 1);
        check("noisy3_code", cal_code, 5);

        // 4 ones of 7 steps on; code 6 then satisfies the detector
        pat = 7'b0101011;
        restart();
        wait_end(1000);
        check("noisy4_done", cal_done, 1);
        check("noisy4_code", cal_code, 6);
        noisy = 1'b0;

        // Restart while settling at code 9
        thresh = 32;
        restart();
        n = 0;
        while ((m_code != 5'd9) && (n < 1000)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_code9", 32'(n < 1000), 1);
        repeat (3) @(posedge clk);
        restart();
        check("rs_cnrst_c1", cnt_nrst, 0);
        check("rs_busy_c1", cal_busy, 1);
        check("rs_code_zero", m_code, 0);
        @(posedge clk);
        #1;
        check("rs_cnrst_c2", cnt_nrst, 0);
        check("rs_busy_c2", cal_busy, 1);
        @(posedge clk);
        #1;
        check("rs_cnrst_rel", cnt_nrst, 1);

        // Asynchronous reset during STEP
        n = 0;
        while (!cnt_dir && (n < 200)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_step", cnt_dir, 1);
        nrst = 1'b0;
        #1;
        check("ar_dir",  cnt_dir, 0);
        check("ar_hold", cnt_hold, 1);
        check("ar_cnrst", cnt_nrst, 0);
        check("ar_busy", cal_busy, 0);
        check("ar_done", cal_done, 0);
        check("ar_fail", cal_fail, 0);
        check("ar_code", cal_code, 0);
        check("ar_cnt_clr", m_code, 0);
        p0 = pulses;
        @(negedge clk) nrst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("held_start_idle_busy", cal_busy, 0);
        check("held_start_idle_cnrst", cnt_nrst, 0);
        check("held_start_no_pulse", pulses - p0, 0);
        restart();
        check("new_rise_busy", cal_busy, 1);
        check("all_pulses_one_wide", max_run, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_aibnd_dcc_cal_ctrl
`default_nettype wire
